// File: rtl/mem_fill_arbiter_if.sv
// Signal bundle between I/D caches, main memory and mem_fill_arbiter.
// slave is the arbiter's view; master is the caches/memory side.
interface mem_fill_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 3
);
  logic              i_miss;
  logic [ADDR_W-1:0] i_miss_addr;
  logic              d_miss;
  logic [ADDR_W-1:0] d_miss_addr;
  logic              d_wr_req;
  logic [ADDR_W-1:0] d_wr_addr;
  logic [DATA_W-1:0] d_wr_data;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  logic              fill_we;
  logic              fill_sel;
  logic [IDX_W-1:0]  fill_word_idx;
  logic [DATA_W-1:0] fill_data;
  logic              i_fill_done;
  logic              d_fill_done;
  logic              d_wr_done;

  modport slave (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr,
    input  d_wr_req, d_wr_addr, d_wr_data,
    input  mem_rdata, mem_rvalid,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    output fill_we, fill_sel, fill_word_idx, fill_data,
    output i_fill_done, d_fill_done, d_wr_done
  );

  modport master (
    output i_miss, i_miss_addr, d_miss, d_miss_addr,
    output d_wr_req, d_wr_addr, d_wr_data,
    output mem_rdata, mem_rvalid,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    input  fill_we, fill_sel, fill_word_idx, fill_data,
    input  i_fill_done, d_fill_done, d_wr_done
  );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Miss/fill controller: arbitrates D-miss > D-store > I-miss onto one memory port and
// streams a block back into the chosen cache; done = 1 + (WORDS_PER_BLOCK-1) + L cycles after request.
module mem_fill_arbiter #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int IDX_W           = 3
) (
  input logic               clk,
  input logic               rst_n,
  mem_fill_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] BLOCK_MASK  = ~(ADDR_W'(2 * WORDS_PER_BLOCK - 1));
  localparam logic [IDX_W:0]    BLOCK_WORDS = (IDX_W + 1)'(WORDS_PER_BLOCK);
  localparam logic [IDX_W:0]    LAST_IDX    = (IDX_W + 1)'(WORDS_PER_BLOCK - 1);
  localparam logic [IDX_W:0]    CNT_ONE     = (IDX_W + 1)'(1);

  state_t            state;
  logic              selD;
  logic [ADDR_W-1:0] base;
  logic [IDX_W:0]    issueCnt;
  logic [IDX_W:0]    retCnt;

  logic              memEn;
  logic              memWr;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic              wrDone;

  logic              fillWe;
  logic              lastWord;

  // base is block aligned, so OR-ing the word offset never carries past the block
  function automatic logic [ADDR_W-1:0] wordAddr(input logic [ADDR_W-1:0] blk,
                                                 input logic [IDX_W:0]    cnt);
    return blk | ADDR_W'({cnt[IDX_W-1:0], 1'b0});
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      selD     <= 1'b0;
      base     <= '0;
      issueCnt <= '0;
      retCnt   <= '0;
      memEn    <= 1'b0;
      memWr    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      wrDone   <= 1'b0;
    end else begin
      memEn    <= 1'b0;
      memWr    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      wrDone   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.d_miss) begin
            state    <= FILL;
            selD     <= 1'b1;
            base     <= bus.d_miss_addr & BLOCK_MASK;
            memEn    <= 1'b1;
            memAddr  <= bus.d_miss_addr & BLOCK_MASK;
            issueCnt <= CNT_ONE;
            retCnt   <= '0;
          end else if (bus.d_wr_req) begin
            state    <= WRITE;
            memEn    <= 1'b1;
            memWr    <= 1'b1;
            memAddr  <= bus.d_wr_addr;
            memWdata <= bus.d_wr_data;
            wrDone   <= 1'b1;
          end else if (bus.i_miss) begin
            state    <= FILL;
            selD     <= 1'b0;
            base     <= bus.i_miss_addr & BLOCK_MASK;
            memEn    <= 1'b1;
            memAddr  <= bus.i_miss_addr & BLOCK_MASK;
            issueCnt <= CNT_ONE;
            retCnt   <= '0;
          end
        end
        FILL: begin
          // issueCnt counts reads already placed on the registered memory port
          if (issueCnt < BLOCK_WORDS) begin
            memEn    <= 1'b1;
            memAddr  <= wordAddr(base, issueCnt);
            issueCnt <= issueCnt + CNT_ONE;
          end
          if (fillWe) begin
            retCnt <= retCnt + CNT_ONE;
            if (lastWord) begin
              state <= IDLE;
            end
          end
        end
        WRITE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Returned words are forwarded in the cycle they arrive so done lines up with the last rvalid
  assign fillWe   = (state == FILL) && bus.mem_rvalid;
  assign lastWord = fillWe && (retCnt == LAST_IDX);

  assign bus.mem_en        = memEn;
  assign bus.mem_wr        = memWr;
  assign bus.mem_addr      = memAddr;
  assign bus.mem_wdata     = memWdata;
  assign bus.d_wr_done     = wrDone;

  assign bus.fill_we       = fillWe;
  assign bus.fill_sel      = fillWe && selD;
  assign bus.fill_word_idx = fillWe ? retCnt[IDX_W-1:0] : '0;
  assign bus.fill_data     = fillWe ? bus.mem_rdata : '0;
  assign bus.i_fill_done   = lastWord && !selD;
  assign bus.d_fill_done   = lastWord && selD;

endmodule
